// File: rtl/rgb_frame_checksum.sv
// Streams the RGB frame region out of SRAM and folds it into a Fletcher-style {sum2, sum1} checksum.
// Optional golden compare on the match output is enabled with `define CHECKSUM_COMPARE_EN.
module rgb_frame_checksum #(
   parameter logic [17:0] BASE_ADDR    = 18'd146944,
   parameter logic [17:0] NUM_WORDS    = 18'd115200,
   parameter int unsigned READ_LATENCY = 2,
   parameter logic [31:0] EXPECTED_SUM = 32'h0
) (
   input  logic        CLOCK_50_I,
   input  logic        resetn,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] SRAM_read_data,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        busy,
   output logic        done,
   output logic [31:0] checksum,
   output logic [17:0] word_count,
   output logic        match
);

   localparam int unsigned AW = 18;
   localparam int unsigned DW = 16;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t                  state, next_state;
   logic [AW-1:0]           rd_cnt;
   logic [READ_LATENCY-1:0] vld_pipe;
   logic [DW-1:0]           sum1_nxt;
   logic                    last_addr_c, pipe_empty_c;
   logic                    frame_start_c, issue_c, acc_c, busy_d, done_d;

   assign SRAM_write_data = 16'd0;
   assign SRAM_we_n       = 1'b1;

   assign last_addr_c  = (rd_cnt == NUM_WORDS - 18'd1);
   assign pipe_empty_c = (vld_pipe == '0);
   assign sum1_nxt     = checksum[DW-1:0] + SRAM_read_data;

   // State register
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= next_state;
   end

   // Next-state logic; abort overrides everything, including a same-cycle start
   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start)        next_state = S_READ;
            S_READ:  if (last_addr_c)  next_state = S_DRAIN;
            S_DRAIN: if (pipe_empty_c) next_state = S_DONE;
            S_DONE:                    next_state = S_IDLE;
         endcase
      end
   end

   // Control decode
   always_comb begin
      frame_start_c = 1'b0;
      issue_c       = 1'b0;
      acc_c         = 1'b0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      if (!abort) begin
         frame_start_c = (state == S_IDLE) && start;
         issue_c       = (state == S_READ);
         acc_c         = vld_pipe[READ_LATENCY-1];
      end
      busy_d = (next_state == S_READ) || (next_state == S_DRAIN);
      done_d = (next_state == S_DONE);
   end

   // Address generation, read-valid delay line and checksum accumulation
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         SRAM_address <= BASE_ADDR;
         rd_cnt       <= '0;
         vld_pipe     <= '0;
         checksum     <= '0;
         word_count   <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         busy <= busy_d;
         done <= done_d;

         if (abort) begin
            vld_pipe <= '0;
         end else begin
            vld_pipe[0] <= issue_c;
            for (int i = 1; i < int'(READ_LATENCY); i++) vld_pipe[i] <= vld_pipe[i-1];
         end

         if (frame_start_c) begin
            SRAM_address <= BASE_ADDR;
            rd_cnt       <= '0;
         end else if (issue_c && !last_addr_c) begin
            SRAM_address <= SRAM_address + 18'd1;
            rd_cnt       <= rd_cnt + 18'd1;
         end

         if (frame_start_c) begin
            checksum   <= '0;
            word_count <= '0;
         end else if (acc_c) begin
            checksum   <= {checksum[31:16] + sum1_nxt, sum1_nxt};
            word_count <= word_count + 18'd1;
         end
      end
   end

`ifdef CHECKSUM_COMPARE_EN
   // Golden compare captured as the final checksum enters S_DONE
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn)                                        match <= 1'b0;
      else if (frame_start_c)                             match <= 1'b0;
      else if (state == S_DRAIN && next_state == S_DONE)  match <= (checksum == EXPECTED_SUM);
   end
`else
   logic unused_expected;
   assign unused_expected = ^EXPECTED_SUM;
   assign match           = 1'b0;
`endif

endmodule
